// File: rtl/lot_gate_tracker.sv
// Two-beam parking gate tracker: decodes car entry/exit sequences from sensors a (outer)
// and b (inner), and keeps a BCD occupancy count with full/empty flags and a dwell-timeout fault.
module lot_gate_tracker #(
    parameter logic [7:0]  CAPACITY       = 8'h20,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    output logic [7:0] count,
    output logic       entry_pulse,
    output logic       exit_pulse,
    output logic       reject,
    output logic       full,
    output logic       empty,
    output logic       fault
);
    localparam int DW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_MAX = DW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, E1, E2, E3, X1, X2, X3, FAULT} state_t;

    state_t        state_reg, state_next;
    logic [DW-1:0] dwell_reg;
    logic [7:0]    count_reg;
    logic          entry_pulse_reg, exit_pulse_reg, reject_reg;
    logic          entry_ev, exit_ev, mid_seq;
    logic [1:0]    sens;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign sens    = {a, b};
    assign mid_seq = (state_reg != IDLE) && (state_reg != FAULT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Exit states mirror the entry states with the two beams swapped.
    always_comb begin
        state_next = state_reg;
        entry_ev   = 1'b0;
        exit_ev    = 1'b0;
        case (state_reg)
            IDLE: case (sens)
                2'b10:   state_next = E1;
                2'b01:   state_next = X1;
                2'b11:   state_next = FAULT;
                default: state_next = IDLE;
            endcase
            E1: case (sens)
                2'b11:   state_next = E2;
                2'b00:   state_next = IDLE;
                2'b01:   state_next = FAULT;
                default: state_next = E1;
            endcase
            E2: case (sens)
                2'b01:   state_next = E3;
                2'b10:   state_next = E1;
                2'b00:   state_next = FAULT;
                default: state_next = E2;
            endcase
            E3: case (sens)
                2'b00: begin
                    state_next = IDLE;
                    entry_ev   = 1'b1;
                end
                2'b11:   state_next = E2;
                2'b10:   state_next = FAULT;
                default: state_next = E3;
            endcase
            X1: case (sens)
                2'b11:   state_next = X2;
                2'b00:   state_next = IDLE;
                2'b10:   state_next = FAULT;
                default: state_next = X1;
            endcase
            X2: case (sens)
                2'b10:   state_next = X3;
                2'b01:   state_next = X1;
                2'b00:   state_next = FAULT;
                default: state_next = X2;
            endcase
            X3: case (sens)
                2'b00: begin
                    state_next = IDLE;
                    exit_ev    = 1'b1;
                end
                2'b11:   state_next = X2;
                2'b01:   state_next = FAULT;
                default: state_next = X3;
            endcase
            FAULT: state_next = (sens == 2'b00) ? IDLE : FAULT;
            default: state_next = IDLE;
        endcase

        // A car stalled mid-sequence too long is treated as a sensor fault.
        if (mid_seq && (state_next == state_reg) && (dwell_reg == DWELL_MAX))
            state_next = FAULT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dwell_reg <= '0;
        else if (!mid_seq || (state_next != state_reg))
            dwell_reg <= '0;
        else
            dwell_reg <= dwell_reg + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg       <= 8'h00;
            entry_pulse_reg <= 1'b0;
            exit_pulse_reg  <= 1'b0;
            reject_reg      <= 1'b0;
        end else begin
            entry_pulse_reg <= entry_ev;
            exit_pulse_reg  <= exit_ev;
            reject_reg      <= 1'b0;
            if (entry_ev) begin
                if (count_reg < CAPACITY)
                    count_reg <= bcd_inc(count_reg);
                else
                    reject_reg <= 1'b1;
            end else if (exit_ev) begin
                if (count_reg != 8'h00)
                    count_reg <= bcd_dec(count_reg);
                else
                    reject_reg <= 1'b1;
            end
        end
    end

    assign count       = count_reg;
    assign entry_pulse = entry_pulse_reg;
    assign exit_pulse  = exit_pulse_reg;
    assign reject      = reject_reg;
    assign full        = (count_reg == CAPACITY);
    assign empty       = (count_reg == 8'h00);
    assign fault       = (state_reg == FAULT);
endmodule

// File: tb/tb_lot_gate_tracker.sv
// Bench for lot_gate_tracker: a sequence-table model with a decimal occupancy counter,
// checked every falling edge, plus literal expectations for the key scenarios.
module tb_lot_gate_tracker;
    localparam logic [7:0] CAP     = 8'h20;
    localparam int         CAP_DEC = 20;
    localparam int         TMO     = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic [7:0] count;
    logic       entry_pulse, exit_pulse, reject, full, empty, fault;

    int tests = 0;
    int fails = 0;

    // Model: direction (0 none, 1 entry, 2 exit), step index into a pattern list framed by 00.
    int         m_occ, m_dir, m_step, m_dwell;
    bit         m_fault, m_entry, m_exit, m_reject;
    bit         cmp_en = 1'b0;
    logic [1:0] ent_seq [5] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] ext_seq [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};

    lot_gate_tracker #(.CAPACITY(CAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .a(a), .b(b), .count(count),
        .entry_pulse(entry_pulse), .exit_pulse(exit_pulse), .reject(reject),
        .full(full), .empty(empty), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_occ = 0; m_dir = 0; m_step = 0; m_dwell = 0;
        m_fault = 0; m_entry = 0; m_exit = 0; m_reject = 0;
    endtask

    task automatic finish_event();
        if (m_dir == 1) begin
            m_entry = 1;
            if (m_occ < CAP_DEC) m_occ++; else m_reject = 1;
        end else begin
            m_exit = 1;
            if (m_occ > 0) m_occ--; else m_reject = 1;
        end
    endtask

    task automatic model_step(input logic [1:0] ab);
        logic [1:0] cur, nxt, prv;
        m_entry = 0; m_exit = 0; m_reject = 0;
        if (m_fault) begin
            if (ab == 2'b00) m_fault = 0;
        end else if (m_dir == 0) begin
            if (ab == 2'b10) begin m_dir = 1; m_step = 1; m_dwell = 0; end
            else if (ab == 2'b01) begin m_dir = 2; m_step = 1; m_dwell = 0; end
            else if (ab == 2'b11) m_fault = 1;
        end else begin
            cur = (m_dir == 1) ? ent_seq[m_step]     : ext_seq[m_step];
            nxt = (m_dir == 1) ? ent_seq[m_step + 1] : ext_seq[m_step + 1];
            prv = (m_dir == 1) ? ent_seq[m_step - 1] : ext_seq[m_step - 1];
            if (ab == cur) begin
                if (m_dwell == TMO - 1) begin m_fault = 1; m_dir = 0; end
                else m_dwell++;
            end else if (ab == nxt) begin
                if (m_step == 3) begin finish_event(); m_dir = 0; end
                else m_step++;
                m_dwell = 0;
            end else if (ab == prv) begin
                if (m_step == 1) m_dir = 0; else m_step--;
                m_dwell = 0;
            end else begin
                m_fault = 1; m_dir = 0;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("count",  count,                to_bcd(m_occ));
            check("entry",  {7'd0, entry_pulse},  {7'd0, m_entry});
            check("exit",   {7'd0, exit_pulse},   {7'd0, m_exit});
            check("reject", {7'd0, reject},       {7'd0, m_reject});
            check("full",   {7'd0, full},         {7'd0, (m_occ == CAP_DEC)});
            check("empty",  {7'd0, empty},        {7'd0, (m_occ == 0)});
            check("fault",  {7'd0, fault},        {7'd0, m_fault});
        end
    end

    task automatic apply(input logic [1:0] ab);
        {a, b} = ab;
        @(posedge clk);
        model_step(ab);
        #1;
    endtask

    task automatic enter_car();
        apply(2'b10); apply(2'b11); apply(2'b01); apply(2'b00);
    endtask

    task automatic exit_car();
        apply(2'b01); apply(2'b11); apply(2'b10); apply(2'b00);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {a, b} = 2'b00;
        model_reset();
        #1;
        check("rst_count_async", count, 8'h00);
        check("rst_no_entry", {7'd0, entry_pulse}, 8'd0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        model_reset();
        cmp_en = 1'b1;
        @(negedge clk);
        check("reset_count", count, 8'h00);
        check("reset_empty", {7'd0, empty}, 8'd1);
        check("reset_full",  {7'd0, full},  8'd0);
        check("reset_fault", {7'd0, fault}, 8'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        enter_car();
        $display("[TB] first entry: count=%h entry_pulse=%b", count, entry_pulse);
        check("first_entry_pulse", {7'd0, entry_pulse}, 8'd1);
        check("first_entry_count", count, 8'h01);
        check("first_entry_empty", {7'd0, empty}, 8'd0);
        apply(2'b00);
        check("entry_pulse_one_cycle", {7'd0, entry_pulse}, 8'd0);

        for (int i = 0; i < 18; i++) enter_car();
        check("count_19", count, 8'h19);
        enter_car();
        $display("[TB] entry to capacity: count=%h full=%b", count, full);
        check("carry_to_20", count, 8'h20);
        check("full_at_20", {7'd0, full}, 8'd1);
        enter_car();
        $display("[TB] entry at full: pulse=%b reject=%b count=%h", entry_pulse, reject, count);
        check("full_entry_pulse", {7'd0, entry_pulse}, 8'd1);
        check("full_entry_reject", {7'd0, reject}, 8'd1);
        check("full_entry_hold", count, 8'h20);
        exit_car();
        $display("[TB] exit from full: count=%h", count);
        check("borrow_to_19", count, 8'h19);
        check("full_clears", {7'd0, full}, 8'd0);

        do_reset();
        exit_car();
        $display("[TB] exit at empty: pulse=%b reject=%b count=%h", exit_pulse, reject, count);
        check("empty_exit_pulse", {7'd0, exit_pulse}, 8'd1);
        check("empty_exit_reject", {7'd0, reject}, 8'd1);
        check("empty_exit_hold", count, 8'h00);

        apply(2'b10); apply(2'b11); apply(2'b10); apply(2'b00);
        $display("[TB] back-out: count=%h entry_pulse=%b", count, entry_pulse);
        check("backout_no_pulse", {7'd0, entry_pulse}, 8'd0);
        check("backout_count", count, 8'h00);
        enter_car();
        check("after_backout_entry", count, 8'h01);

        apply(2'b10); apply(2'b11); apply(2'b01); apply(2'b11); apply(2'b01); apply(2'b00);
        check("rocking_entry", count, 8'h02);
        apply(2'b01); apply(2'b11); apply(2'b10); apply(2'b11); apply(2'b10); apply(2'b00);
        $display("[TB] rocking exit: count=%h exit_pulse=%b", count, exit_pulse);
        check("rocking_exit", count, 8'h01);

        apply(2'b10); apply(2'b01);
        check("e1_cross_fault", {7'd0, fault}, 8'd1);
        apply(2'b00);
        check("fault_recover", {7'd0, fault}, 8'd0);

        apply(2'b00); apply(2'b11);
        $display("[TB] both beams from idle: fault=%b", fault);
        check("idle_11_fault", {7'd0, fault}, 8'd1);
        apply(2'b00);
        check("idle_11_recover", {7'd0, fault}, 8'd0);
        for (int i = 0; i < 16; i++) apply(2'b10);
        check("dwell_not_yet", {7'd0, fault}, 8'd0);
        apply(2'b10);
        $display("[TB] dwell timeout: fault=%b", fault);
        check("dwell_timeout", {7'd0, fault}, 8'd1);
        apply(2'b00);
        check("timeout_recover", {7'd0, fault}, 8'd0);

        for (int i = 0; i < 4; i++) enter_car();
        check("count_05", count, 8'h05);
        apply(2'b10); apply(2'b11); apply(2'b01);
        do_reset();
        apply(2'b00);
        $display("[TB] reset in E3: count=%h entry_pulse=%b", count, entry_pulse);
        check("e3_reset_count", count, 8'h00);
        check("e3_reset_no_pulse", {7'd0, entry_pulse}, 8'd0);
        enter_car();
        check("post_reset_entry", count, 8'h01);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
